// File: rtl/switch_input_debouncer.sv
// Eight-bit switch conditioner: two-flop synchroniser per bit, then an independent
// saturating debounce counter per bit that flips the clean output after a sustained difference.
module switch_input_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_WIDTH       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] raw_in,
   output logic [7:0] data,
   output logic       changed,
   output logic       stable
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_WIDTH) - 1) begin : g_bad_param
      $error("switch_input_debouncer: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
   end

   logic [7:0]           sync1_q;
   logic [7:0]           sync2_q;
   logic [7:0]           data_q;
   logic [7:0]           data_d;
   logic                 changed_q;
   logic                 changed_d;
   logic [CNT_WIDTH-1:0] cnt_q [8];
   logic [CNT_WIDTH-1:0] cnt_d [8];
   logic [7:0]           cnt_zero;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      data_d = data_q;
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = cnt_q[i];
         if (ena) begin
            if (sync2_q[i] == data_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               data_d[i] = sync2_q[i];
               cnt_d[i]  = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
         end
      end
      changed_d = (data_d != data_q);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         data_q    <= '0;
         changed_q <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         // The synchroniser runs regardless of ena so s2 keeps tracking the pins.
         sync1_q   <= raw_in;
         sync2_q   <= sync1_q;
         data_q    <= data_d;
         changed_q <= changed_d;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      cnt_zero = '0;
      for (int i = 0; i < 8; i++) begin
         cnt_zero[i] = (cnt_q[i] == '0);
      end
   end

   assign data    = data_q;
   assign changed = changed_q;
   assign stable  = (&cnt_zero) && (sync2_q == data_q);

endmodule

// File: tb/tb_switch_input_debouncer.sv
// Bench for switch_input_debouncer: a D=4 instance checked every cycle against a
// sliding-window model, plus a D=1 instance checked from a vector table.
module tb_switch_input_debouncer;

   localparam int D4 = 4;

   logic       clk;
   logic       rst_n;
   logic       ena4, ena1;
   logic [7:0] raw4, raw1;
   logic [7:0] data4, data1;
   logic       changed4, changed1;
   logic       stable4, stable1;

   int n_cmp;
   int n_err;

   switch_input_debouncer #(.DEBOUNCE_CYCLES(D4), .CNT_WIDTH(16)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena4), .raw_in(raw4),
      .data(data4), .changed(changed4), .stable(stable4)
   );

   switch_input_debouncer #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena1), .raw_in(raw1),
      .data(data1), .changed(changed1), .stable(stable1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a bit flips when its last D enabled-edge samples of the
   // synchronised input all disagree with the current clean value.
   logic [7:0] m_s1, m_s2, m_data;
   logic       m_changed;
   logic [7:0] hist [$];

   task automatic m_reset();
      m_s1 = '0; m_s2 = '0; m_data = '0; m_changed = 1'b0;
      hist.delete();
   endtask

   task automatic m_edge(input logic [7:0] raw, input logic en);
      logic [7:0] flips;
      logic       all_diff;
      flips = '0;
      if (en) begin
         hist.push_back(m_s2);
         if (hist.size() > 16) void'(hist.pop_front());
         for (int i = 0; i < 8; i++) begin
            if (hist.size() >= D4) begin
               all_diff = 1'b1;
               for (int k = 0; k < D4; k++)
                  if (hist[hist.size() - 1 - k][i] == m_data[i]) all_diff = 1'b0;
               flips[i] = all_diff;
            end
         end
         m_data    = m_data ^ flips;
         m_changed = |flips;
      end else begin
         m_changed = 1'b0;
      end
      m_s2 = m_s1;
      m_s1 = raw;
   endtask

   function automatic logic m_stable();
      logic [7:0] last;
      m_stable = 1'b1;
      last = (hist.size() > 0) ? hist[hist.size() - 1] : m_data;
      for (int i = 0; i < 8; i++) begin
         if (m_s2[i] != m_data[i]) m_stable = 1'b0;
         if (last[i] != m_data[i]) m_stable = 1'b0;
      end
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // One clock edge: advance the model, then compare the D=4 outputs just after the edge.
   task automatic tick();
      m_edge(raw4, ena4);
      @(posedge clk);
      #1;
      check("model_data", data4, m_data);
      check("model_changed", {7'd0, changed4}, {7'd0, m_changed});
      check("model_stable", {7'd0, stable4}, {7'd0, m_stable()});
   endtask

   // Asynchronous reset asserted between edges, released mid-cycle after one edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      check("rst_data", data4, 8'h00);
      check("rst_changed", {7'd0, changed4}, 8'h00);
      check("rst_stable", {7'd0, stable4}, 8'h01);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [7:0] raw;
      logic       ena;
      logic [7:0] data;
      logic       changed;
      logic       stable;
   } vec_t;

   vec_t vecs [13];

   initial begin
      int n;
      logic seen;

      n_cmp = 0;
      n_err = 0;
      vecs[0]  = '{8'h55, 1'b1, 8'h00, 1'b0, 1'b1};
      vecs[1]  = '{8'h55, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{8'h55, 1'b1, 8'h55, 1'b1, 1'b1};
      vecs[3]  = '{8'h55, 1'b1, 8'h55, 1'b0, 1'b1};
      vecs[4]  = '{8'h00, 1'b0, 8'h55, 1'b0, 1'b1};
      vecs[5]  = '{8'h00, 1'b0, 8'h55, 1'b0, 1'b0};
      vecs[6]  = '{8'h00, 1'b0, 8'h55, 1'b0, 1'b0};
      vecs[7]  = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
      vecs[8]  = '{8'h0F, 1'b1, 8'h00, 1'b0, 1'b1};
      vecs[9]  = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[10] = '{8'h00, 1'b1, 8'h0F, 1'b1, 1'b0};
      vecs[11] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
      vecs[12] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b1};

      rst_n = 1'b1;
      ena4 = 1'b1; ena1 = 1'b1;
      raw4 = 8'hFF; raw1 = 8'h00;
      m_reset();
      #1;
      rst_n = 1'b0;
      #2;
      check("por_data", data4, 8'h00);
      check("por_changed", {7'd0, changed4}, 8'h00);
      check("por_stable", {7'd0, stable4}, 8'h01);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset release with all switches high: flip lands on edge N+5.
      for (int t = 1; t <= 7; t++) begin
         tick();
         if (t == 5) check("rel_data_pre", data4, 8'h00);
         if (t == 6) begin
            check("rel_data", data4, 8'hFF);
            check("rel_changed", {7'd0, changed4}, 8'h01);
         end
         if (t == 7) begin
            check("rel_changed_off", {7'd0, changed4}, 8'h00);
            check("rel_stable", {7'd0, stable4}, 8'h01);
         end
      end

      // Glitch of 3 samples at s2 is rejected.
      raw4 = 8'h00;
      do_reset();
      raw4 = 8'h08;
      seen = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         if (t == 4) raw4 = 8'h00;
         tick();
         if (changed4) seen = 1'b1;
      end
      check("glitch3_data", data4, 8'h00);
      check("glitch3_nopulse", {7'd0, seen}, 8'h00);

      // Glitch of 4 samples is accepted with a single pulse.
      raw4 = 8'h08;
      n = 0;
      for (int t = 1; t <= 9; t++) begin
         if (t == 5) raw4 = 8'h00;
         tick();
         if (changed4) n++;
         if (t == 6) check("glitch4_data", data4, 8'h08);
      end
      check("glitch4_pulses", 8'(n), 8'd1);

      // Independent bits with staggered edges.
      raw4 = 8'h00;
      do_reset();
      raw4 = 8'h80;
      for (int t = 1; t <= 9; t++) begin
         if (t == 3) raw4 = 8'h81;
         tick();
         if (t == 6) begin
            check("indep_data80", data4, 8'h80);
            check("indep_pulse1", {7'd0, changed4}, 8'h01);
         end
         if (t == 7) check("indep_gap", {7'd0, changed4}, 8'h00);
         if (t == 8) begin
            check("indep_data81", data4, 8'h81);
            check("indep_pulse2", {7'd0, changed4}, 8'h01);
         end
      end

      // Enable gap over edges N+3..N+5 delays the flip to N+8.
      raw4 = 8'h00;
      do_reset();
      raw4 = 8'h20;
      for (int t = 1; t <= 10; t++) begin
         ena4 = !(t >= 4 && t <= 6);
         tick();
         if (t >= 4 && t <= 6) begin
            check("ena_gap_changed", {7'd0, changed4}, 8'h00);
            check("ena_gap_stable", {7'd0, stable4}, 8'h00);
         end
         if (t == 8) check("ena_data_pre", data4, 8'h00);
         if (t == 9) begin
            check("ena_data", data4, 8'h20);
            check("ena_changed", {7'd0, changed4}, 8'h01);
         end
      end
      ena4 = 1'b1;

      // Reset in the middle of a count.
      raw4 = 8'h3C;
      for (int t = 1; t <= 8; t++) tick();
      check("mid_setup", data4, 8'h3C);
      raw4 = 8'h00;
      for (int t = 1; t <= 4; t++) tick();
      do_reset();
      seen = 1'b0;
      for (int t = 1; t <= 10; t++) begin
         tick();
         if (changed4 || !stable4) seen = 1'b1;
      end
      check("mid_quiet", {7'd0, seen}, 8'h00);

      // D=1 instance from the vector table.
      do_reset();
      for (int v = 0; v < 13; v++) begin
         raw1 = vecs[v].raw;
         ena1 = vecs[v].ena;
         tick();
         check($sformatf("d1_data[%0d]", v), data1, vecs[v].data);
         check($sformatf("d1_changed[%0d]", v), {7'd0, changed1}, {7'd0, vecs[v].changed});
         check($sformatf("d1_stable[%0d]", v), {7'd0, stable1}, {7'd0, vecs[v].stable});
      end
      ena1 = 1'b1;

      // Randomised run on the D=4 instance against the window model.
      do_reset();
      for (int t = 0; t < 3000; t++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 5) == 0) raw4[b] = ~raw4[b];
         ena4 = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 499) == 0) do_reset();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/switch_input_debouncer.md
Name: switch_input_debouncer

Overview:
Input-conditioning stage placed directly upstream of the 8-bit priority encoder / 7-segment decoder. It takes 8 raw, asynchronous, bouncing switch inputs, synchronises them into the clk domain and debounces each bit independently. It then presents a clean 8-bit data word to the encoder's data input. It also provides a one-cycle change strobe and a settled flag for optional downstream use.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive enabled cycles a synchronised bit must differ from its debounced value before the debounced value flips; legal range 1 .. 2^CNT_WIDTH-1
CNT_WIDTH, 16, width of each per-bit debounce counter

Ports:
clk  input  1  single system clock; all state on rising edge
rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
ena  input  1  count enable; when low, debounce counters and outputs hold
raw_in  input  8  raw switch levels, asynchronous to clk
data  output  8  debounced word, feeds priority encoder data[7:0]
changed  output  1  one-cycle pulse: at least one data bit flipped on the previous edge
stable  output  1  high when every bit is settled: counter zero and synchronised input equals data

Behaviour:
- Reset (rst_n low, asynchronous): sync stage 1 = 0, sync stage 2 = 0, all counters = 0, data = 8'h00, changed = 0. stable therefore reads 1.
- Reset is asserted asynchronously and released on any edge. The first edge after release behaves as a normal cycle.
- Synchroniser: 2 flip-flops per bit (s1 <= raw_in; s2 <= s1). It runs every cycle regardless of ena.
- Per bit i, each edge with ena = 1:
  - if s2[i] == data[i]: cnt[i] <= 0.
  - else if cnt[i] == DEBOUNCE_CYCLES-1: data[i] <= s2[i] and cnt[i] <= 0.
  - else: cnt[i] <= cnt[i]+1.
- ena = 0: cnt and data hold; changed <= 0.
- Latency: raw_in[i] changes and is held stable from before edge N. data[i] shows the new value after edge N+1+DEBOUNCE_CYCLES, with no ena gaps.
- Glitch rejection: any return of s2[i] to data[i] before the count completes clears cnt[i]. data[i] does not flip.
  - A pulse that lasts DEBOUNCE_CYCLES-1 cycles at s2 is rejected.
  - A pulse that lasts DEBOUNCE_CYCLES cycles is accepted.
- Bits are fully independent. Several bits may flip on the same edge.
- changed: registered. It is 1 for exactly one cycle after any edge on which at least one data bit flipped, otherwise 0. Simultaneous flips on one edge give a single pulse. Flips on back-to-back edges give changed high for two consecutive cycles.
- stable: combinational from registers. stable = (all cnt == 0) AND (s2 == data).
- DEBOUNCE_CYCLES = 1: a bit flips on the first enabled edge on which s2 differs from data; the counter never leaves 0.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Reset mid-count: the count is discarded; data returns to 0 immediately (asynchronously).
- No combinational path from raw_in to any output.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4: hold rst_n=0, raw_in=8'hFF -> data=8'h00, changed=0, stable=1. Release, raw_in held at 8'hFF from before edge N -> data=8'hFF after edge N+5, changed=1 only in the cycle after edge N+5, stable=1 from then on.
- Glitch, D=4, data=8'h00: raw_in[3]=1 long enough that s2[3] is high for 3 cycles, then 0 -> data stays 8'h00, changed never 1, cnt[3] peaks at 3 then clears. Repeat with s2[3] high for 4 cycles -> data=8'h08, single changed pulse.
- Independent bits, D=4: raw_in[7] rises before edge N, raw_in[0] rises before edge N+2 -> data=8'h80 after N+5, then 8'h81 after N+7, two separate one-cycle changed pulses.
- Enable gating, D=4: raw_in[5] rises before edge N, ena=0 for edges N+3..N+5 -> flip delayed to edge N+8. changed stays 0 while ena=0. s2 still tracks raw_in during the gap.
- Reset mid-operation: data=8'h3C, raw_in=8'h00 mid-count -> assert rst_n asynchronously between edges. data=8'h00 and changed=0 immediately. After release with raw_in=8'h00, stable=1 and there are no pulses.
- D=1: raw_in toggles 8'h00->8'h55 before edge N -> data=8'h55 after edge N+2, changed pulse after N+2.
